// File: rtl/aes_uart_initiator_pkg.sv
// Shared types and sizing for the AES-over-UART initiator and its byte sender.
package aes_uart_initiator_pkg;

    localparam int unsigned DEFAULT_N  = 128;
    localparam int unsigned NUM_FRAMES = DEFAULT_N / 8;
    localparam int unsigned FCNT_W     = $clog2(NUM_FRAMES) + 1;

    typedef logic [FCNT_W-1:0] fcnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EN_LOW,
        ST_SEND_KEY,
        ST_SEND_DATA,
        ST_RECV,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_READY,
        TX_HOLD,
        TX_GAP
    } tx_state_t;

    // Frame count for an n-bit block (one UART byte per frame).
    function automatic int unsigned num_frames(input int unsigned n);
        return n / 8;
    endfunction

    // Frame counter width for an n-bit block; one spare bit above the index.
    function automatic int unsigned fcnt_width(input int unsigned n);
        return $clog2(n / 8) + 1;
    endfunction

endpackage

// File: rtl/aes_uart_byte_sender.sv
// Single-byte UART handshake: latch a byte, wait for the UART to be idle,
// hold start/data until the UART takes it, then enforce an idle gap.
module aes_uart_byte_sender
    import aes_uart_initiator_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] byte_data,
    output logic       sent,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_ready
);

    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [31:0] gap_cnt;

    // Next-state and handshake outputs; start is high only while holding a byte.
    always_comb begin
        state_nxt     = state;
        sent          = 1'b0;
        uart_tx_start = 1'b0;
        case (state)
            TX_IDLE: begin
                if (send) state_nxt = TX_WAIT_READY;
            end
            TX_WAIT_READY: begin
                if (uart_tx_ready) state_nxt = TX_HOLD;
            end
            TX_HOLD: begin
                uart_tx_start = 1'b1;
                if (!uart_tx_ready) begin
                    sent      = 1'b1;
                    state_nxt = TX_GAP;
                end
            end
            TX_GAP: begin
                if (gap_cnt >= GAP_CYCLES) state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // State register, byte latch and gap counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= TX_IDLE;
            uart_tx_data <= '0;
            gap_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state == TX_IDLE && send) uart_tx_data <= byte_data;
            if (state == TX_GAP) gap_cnt <= gap_cnt + 32'd1;
            else                 gap_cnt <= '0;
        end
    end

endmodule

// File: rtl/aes_uart_initiator.sv
// Drives a peer AES encryptor over UART: optional key session, data block,
// then collects the ciphertext with a per-byte receive timeout.
module aes_uart_initiator
    import aes_uart_initiator_pkg::*;
#(
    parameter int unsigned N                 = DEFAULT_N,
    parameter int unsigned GAP_CYCLES        = 1000,
    parameter int unsigned ENABLE_LOW_CYCLES = 100,
    parameter int unsigned RX_TIMEOUT        = 2000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         load_key,
    input  logic [N-1:0] key_in,
    input  logic [N-1:0] data_in,
    output logic         aes_enable,
    output logic         uart_tx_start,
    output logic [7:0]   uart_tx_data,
    input  logic         uart_tx_ready,
    input  logic [7:0]   uart_rx_data,
    input  logic         uart_rx_valid,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned   NF   = num_frames(N);
    localparam int unsigned   FW   = fcnt_width(N);
    localparam logic [FW-1:0] LAST = FW'(NF - 1);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  key_r;
    logic [N-1:0]  data_r;
    logic [FW-1:0] fcnt;
    logic [FW-2:0] fidx;
    logic [31:0]   en_cnt;
    logic [31:0]   to_cnt;
    logic          key_sent;
    logic          rx_valid_q;
    logic          rx_edge;
    logic          send;
    logic          sent;
    logic [7:0]    tx_byte;
    logic          timeout;

    assign fidx    = fcnt[FW-2:0];
    assign rx_edge = uart_rx_valid && !rx_valid_q;
    assign timeout = (state == ST_RECV) && (state_nxt == ST_IDLE);

    aes_uart_byte_sender #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_sender (
        .clk          (clk),
        .reset        (reset),
        .send         (send),
        .byte_data    (tx_byte),
        .sent         (sent),
        .uart_tx_start(uart_tx_start),
        .uart_tx_data (uart_tx_data),
        .uart_tx_ready(uart_tx_ready)
    );

    // Select the next outgoing byte, frame 0 first.
    always_comb begin
        send    = 1'b0;
        tx_byte = '0;
        if (state == ST_SEND_KEY) begin
            send    = 1'b1;
            tx_byte = key_r[{fidx, 3'b000} +: 8];
        end else if (state == ST_SEND_DATA) begin
            send    = 1'b1;
            tx_byte = data_r[{fidx, 3'b000} +: 8];
        end
    end

    // Session sequencing plus busy/done decode.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (load_key || !key_sent) ? ST_EN_LOW : ST_SEND_DATA;
            end
            ST_EN_LOW: begin
                if (en_cnt + 32'd1 >= ENABLE_LOW_CYCLES) state_nxt = ST_SEND_KEY;
            end
            ST_SEND_KEY: begin
                if (sent && fcnt == LAST) state_nxt = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (sent && fcnt == LAST) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (rx_edge) begin
                    if (fcnt == LAST) state_nxt = ST_DONE;
                end else if (to_cnt + 32'd1 >= RX_TIMEOUT) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register and counters; every counter restarts on state entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fcnt       <= '0;
            en_cnt     <= '0;
            to_cnt     <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_valid_q <= uart_rx_valid;
            if (state != state_nxt) begin
                fcnt   <= '0;
                en_cnt <= '0;
                to_cnt <= '0;
            end else begin
                case (state)
                    ST_EN_LOW: en_cnt <= en_cnt + 32'd1;
                    ST_SEND_KEY, ST_SEND_DATA: begin
                        if (sent) fcnt <= fcnt + 1'b1;
                    end
                    ST_RECV: begin
                        if (rx_edge) begin
                            fcnt   <= fcnt + 1'b1;
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Captured operands, result assembly, enable, key-sent and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_r      <= '0;
            data_r     <= '0;
            result     <= '0;
            aes_enable <= 1'b0;
            key_sent   <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                key_r  <= key_in;
                data_r <= data_in;
                error  <= 1'b0;
                if (state_nxt == ST_EN_LOW) aes_enable <= 1'b0;
            end
            if (state == ST_EN_LOW && state_nxt == ST_SEND_KEY) aes_enable <= 1'b1;
            if (state == ST_SEND_KEY && state_nxt == ST_SEND_DATA) key_sent <= 1'b1;
            // Last byte lands in the same cycle the state leaves RECV.
            if (state == ST_RECV && rx_edge) result[{fidx, 3'b000} +: 8] <= uart_rx_data;
            if (timeout) begin
                error      <= 1'b1;
                aes_enable <= 1'b0;
                key_sent   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_uart_initiator.sv
// Directed bench for aes_uart_initiator with a UART transmitter model and
// a hand-driven peer response.
module tb_aes_uart_initiator;

    localparam int unsigned N     = 128;
    localparam int unsigned GAP   = 4;
    localparam int unsigned ENLOW = 5;
    localparam int unsigned RXTO  = 60;

    localparam logic [N-1:0] KEY   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [N-1:0] DATA1 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [N-1:0] DATA2 = 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0;
    localparam logic [N-1:0] RESP1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [N-1:0] RESP2 = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [N-1:0] RESP3 = 128'hcfcecdcccbcac9c8c7c6c5c4c3c2c1c0;

    logic         clk;
    logic         reset;
    logic         start;
    logic         load_key;
    logic [N-1:0] key_in;
    logic [N-1:0] data_in;
    logic         aes_enable;
    logic         uart_tx_start;
    logic [7:0]   uart_tx_data;
    logic         uart_tx_ready;
    logic [7:0]   uart_rx_data;
    logic         uart_rx_valid;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic         error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_log [0:511];
    int         gap_log [0:511];
    int         tx_cnt = 0;
    int         done_total = 0;
    int         en_low_total = 0;
    int         ready_hold = 2;

    aes_uart_initiator #(
        .N                (N),
        .GAP_CYCLES       (GAP),
        .ENABLE_LOW_CYCLES(ENLOW),
        .RX_TIMEOUT       (RXTO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_key     (load_key),
        .key_in       (key_in),
        .data_in      (data_in),
        .aes_enable   (aes_enable),
        .uart_tx_start(uart_tx_start),
        .uart_tx_data (uart_tx_data),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .result       (result),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART transmitter model: accepts a byte when start meets ready, then
    // keeps ready low for ready_hold cycles; logs bytes, gaps, done and enable.
    initial begin
        int low_run;
        int hold_left;
        low_run       = 0;
        hold_left     = 0;
        uart_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (done) done_total++;
            if (!aes_enable) en_low_total++;
            if (!uart_tx_start) low_run++;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) uart_tx_ready = 1'b1;
            end else if (uart_tx_start && uart_tx_ready) begin
                if (tx_cnt < 512) begin
                    tx_log[tx_cnt]  = uart_tx_data;
                    gap_log[tx_cnt] = low_run;
                    tx_cnt++;
                end
                low_run       = 0;
                hold_left     = ready_hold;
                uart_tx_ready = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic lk);
        start    = 1'b1;
        load_key = lk;
        @(negedge clk);
        start    = 1'b0;
        load_key = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        uart_rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_block(input logic [N-1:0] v);
        for (int i = 0; i < 16; i++) send_rx(v[8*i +: 8]);
    endtask

    task automatic wait_tx(input int target, input int budget, output logic ok);
        int c;
        c = 0;
        while (tx_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (tx_cnt >= target);
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; load_key = 1'b0;
        key_in = '0; data_in = '0; uart_rx_data = '0; uart_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (aes_enable !== 1'b0) begin n_bad++; $display("FAIL reset_aes_enable: got %b want 0", aes_enable); end
        n_cmp++; if (uart_tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", uart_tx_start); end
        n_cmp++; if (uart_tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", uart_tx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key_session();
        int base, d0, cnt;
        logic ok;
        logic [7:0] e;
        base = tx_cnt; d0 = done_total;
        key_in = KEY; data_in = DATA1;
        pulse_start(1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL key_busy: got %b want 1", busy); end
        cnt = 0;
        while (!aes_enable && cnt < 1000) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt != ENLOW) begin n_bad++; $display("FAIL key_en_low_len: got %0d want %0d", cnt, ENLOW); end
        wait_tx(base + 32, 5000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL key_tx_count: got %0d want %0d", tx_cnt - base, 32); end
        for (int i = 0; i < 32; i++) begin
            e = (i < 16) ? 8'(i) : 8'((i - 16) * 17);
            n_cmp++;
            if (tx_log[base + i] !== e) begin n_bad++; $display("FAIL key_tx_byte[%0d]: got %h want %h", i, tx_log[base + i], e); end
        end
        repeat (3) @(negedge clk);
        send_block(RESP1);
        wait_idle(100, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL key_idle: got busy=%b want 0", busy); end
        n_cmp++; if (result !== RESP1) begin n_bad++; $display("FAIL key_result: got %h want %h", result, RESP1); end
        n_cmp++; if (done_total - d0 != 1) begin n_bad++; $display("FAIL key_done_pulses: got %0d want 1", done_total - d0); end
        n_cmp++; if (aes_enable !== 1'b1) begin n_bad++; $display("FAIL key_enable_kept: got %b want 1", aes_enable); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL key_error: got %b want 0", error); end
    endtask

    task automatic test_back_to_back();
        int base, e0;
        logic ok;
        logic [7:0] e;
        base = tx_cnt; e0 = en_low_total;
        data_in = DATA2;
        pulse_start(1'b0);
        wait_tx(base + 16, 3000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_tx_wait: got %0d want 16", tx_cnt - base); end
        repeat (3) @(negedge clk);
        send_block(RESP2);
        wait_idle(100, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (tx_cnt - base != 16) begin n_bad++; $display("FAIL b2b_tx_count: got %0d want 16", tx_cnt - base); end
        for (int i = 0; i < 16; i++) begin
            e = 8'hA0 + 8'(i);
            n_cmp++;
            if (tx_log[base + i] !== e) begin n_bad++; $display("FAIL b2b_tx_byte[%0d]: got %h want %h", i, tx_log[base + i], e); end
        end
        n_cmp++; if (en_low_total != e0) begin n_bad++; $display("FAIL b2b_enable_drop: got %0d low cycles want 0", en_low_total - e0); end
        n_cmp++; if (result !== RESP2) begin n_bad++; $display("FAIL b2b_result: got %h want %h", result, RESP2); end
    endtask

    task automatic test_ignore();
        int base;
        logic ok;
        for (int i = 0; i < 3; i++) send_rx(8'hEE);
        n_cmp++; if (result !== RESP2) begin n_bad++; $display("FAIL ign_idle_rx: got %h want %h", result, RESP2); end
        base = tx_cnt;
        pulse_start(1'b0);
        wait_tx(base + 16, 3000, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) send_rx(RESP3[8*i +: 8]);
        pulse_start(1'b1);
        for (int i = 8; i < 16; i++) send_rx(RESP3[8*i +: 8]);
        wait_idle(100, ok);
        repeat (20) @(negedge clk);
        n_cmp++; if (result !== RESP3) begin n_bad++; $display("FAIL ign_result: got %h want %h", result, RESP3); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got %b want 0", busy); end
        n_cmp++; if (tx_cnt - base != 16) begin n_bad++; $display("FAIL ign_tx_count: got %0d want 16", tx_cnt - base); end
    endtask

    task automatic test_handshake();
        int base, bad;
        logic ok;
        base = tx_cnt;
        ready_hold = 50;
        pulse_start(1'b0);
        wait_tx(base + 1, 200, ok);
        ready_hold = 2;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hs_first_byte: got %0d want 1", tx_cnt - base); end
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'hA1) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hs_hold_stable: got %0d unstable cycles want 0", bad); end
        wait_tx(base + 16, 3000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hs_tx_count: got %0d want 16", tx_cnt - base); end
        n_cmp++; if (gap_log[base + 1] < 40) begin n_bad++; $display("FAIL hs_long_gap: got %0d want >=40", gap_log[base + 1]); end
        bad = 0;
        for (int i = 1; i < 16; i++) if (gap_log[base + i] < int'(GAP)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hs_min_gap: got %0d short gaps want 0", bad); end
        repeat (3) @(negedge clk);
        send_block(RESP2);
        wait_idle(100, ok);
        n_cmp++; if (result !== RESP2) begin n_bad++; $display("FAIL hs_result: got %h want %h", result, RESP2); end
    endtask

    task automatic test_timeout();
        int base, cnt;
        logic ok;
        base = tx_cnt;
        pulse_start(1'b0);
        wait_tx(base + 16, 3000, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) send_rx(8'h30 + 8'(i));
        cnt = 0;
        while (!error && cnt < 500) begin @(negedge clk); cnt++; end
        n_cmp++; if (cnt != int'(RXTO) - 3) begin n_bad++; $display("FAIL to_delay: got %0d want %0d", cnt, RXTO - 3); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL to_error: got %b want 1", error); end
        n_cmp++; if (aes_enable !== 1'b0) begin n_bad++; $display("FAIL to_enable: got %b want 0", aes_enable); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy: got %b want 0", busy); end
        base = tx_cnt;
        pulse_start(1'b0);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL to_error_clear: got %b want 0", error); end
        cnt = 0;
        while (!aes_enable && cnt < 1000) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt != ENLOW) begin n_bad++; $display("FAIL to_en_low_len: got %0d want %0d", cnt, ENLOW); end
        wait_tx(base + 32, 5000, ok);
        n_cmp++; if (tx_log[base] !== 8'h00 || tx_log[base + 15] !== 8'h0f) begin n_bad++; $display("FAIL to_rekey: got %h..%h want 00..0f", tx_log[base], tx_log[base + 15]); end
        n_cmp++; if (tx_log[base + 16] !== 8'hA0) begin n_bad++; $display("FAIL to_data0: got %h want a0", tx_log[base + 16]); end
        repeat (3) @(negedge clk);
        send_block(RESP1);
        wait_idle(100, ok);
        n_cmp++; if (result !== RESP1) begin n_bad++; $display("FAIL to_result: got %h want %h", result, RESP1); end
    endtask

    task automatic test_reset_mid();
        int base, snap, cnt;
        logic ok;
        base = tx_cnt;
        pulse_start(1'b0);
        wait_tx(base + 7, 2000, ok);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (aes_enable !== 1'b0) begin n_bad++; $display("FAIL rst_aes_enable: got %b want 0", aes_enable); end
        n_cmp++; if (uart_tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_tx_start: got %b want 0", uart_tx_start); end
        n_cmp++; if (uart_tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data: got %h want 00", uart_tx_data); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got busy=%b done=%b error=%b want 000", busy, done, error); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rst_result: got %h want 0", result); end
        snap = tx_cnt;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (tx_cnt != snap) begin n_bad++; $display("FAIL rst_no_tx: got %0d extra bytes want 0", tx_cnt - snap); end
        pulse_start(1'b0);
        cnt = 0;
        while (!aes_enable && cnt < 1000) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt != ENLOW) begin n_bad++; $display("FAIL rst_en_low_len: got %0d want %0d", cnt, ENLOW); end
        wait_tx(snap + 32, 5000, ok);
        n_cmp++; if (tx_log[snap] !== 8'h00 || tx_log[snap + 16] !== 8'hA0) begin n_bad++; $display("FAIL rst_rekey: got %h/%h want 00/a0", tx_log[snap], tx_log[snap + 16]); end
        repeat (3) @(negedge clk);
        send_block(RESP3);
        wait_idle(100, ok);
        n_cmp++; if (result !== RESP3) begin n_bad++; $display("FAIL rst_result_after: got %h want %h", result, RESP3); end
    endtask

    initial begin
        test_reset();
        test_key_session();
        test_back_to_back();
        test_ignore();
        test_handshake();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
